// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
// Optional UART_RX_PARITY_EN widens the state encoding to make room for PARITY.
package uart_pkg;

    localparam int unsigned OVERSAMPLE = 16;
    localparam int unsigned MID_TICK   = 7;

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {
        IDLE   = 3'b000,
        START  = 3'b001,
        DATA   = 3'b010,
        STOP   = 3'b011,
        PARITY = 3'b100
    } rx_state_t;
`else
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        START = 2'b01,
        DATA  = 2'b10,
        STOP  = 2'b11
    } rx_state_t;
`endif

endpackage

// File: rtl/uart_rx_sampler_if.sv
// Serial-in / byte-out bundle of the UART receiver.
// UART_RX_PARITY_EN adds parity_odd and parity_err.
interface uart_rx_sampler_if #(
    parameter int unsigned DBIT = 8
);
    logic            s_tick;
    logic            rx;
    logic [DBIT-1:0] dout;
    logic            rx_done_tick;
    logic            framing_err;
`ifdef UART_RX_PARITY_EN
    logic            parity_odd;
    logic            parity_err;

    modport master (
        input  s_tick, rx, parity_odd,
        output dout, rx_done_tick, framing_err, parity_err
    );
    modport slave (
        output s_tick, rx, parity_odd,
        input  dout, rx_done_tick, framing_err, parity_err
    );
`else
    modport master (
        input  s_tick, rx,
        output dout, rx_done_tick, framing_err
    );
    modport slave (
        output s_tick, rx,
        input  dout, rx_done_tick, framing_err
    );
`endif
endinterface

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for asynchronous idle-high lines; both flops reset to 1.
module uart_sync2 (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);
    logic meta;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/uart_rx_sampler.sv
// 16x-oversampling UART receiver: start detect, mid-bit data sampling, stop check.
// Define UART_RX_PARITY_EN to insert a parity bit between data and stop.
module uart_rx_sampler #(
    parameter int unsigned DBIT    = 8,
    parameter int unsigned SB_TICK = 16
) (
    input  logic              clk,
    input  logic              reset,
    uart_rx_sampler_if.master bus
);
    import uart_pkg::*;

    localparam int unsigned SW = 5;
    localparam int unsigned NW = $clog2(DBIT);

    rx_state_t       state;
    logic [SW-1:0]   s_cnt;
    logic [NW-1:0]   n_cnt;
    logic [DBIT-1:0] shift_reg;
    logic [DBIT-1:0] dout_q;
    logic            done_q;
    logic            ferr_q;
    logic            rx_s;
`ifdef UART_RX_PARITY_EN
    logic            par_bit;
    logic            perr_q;
`endif

    uart_sync2 u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (bus.rx),
        .q     (rx_s)
    );

    // Receive FSM; counters only move on oversample ticks except for start detection
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            s_cnt     <= '0;
            n_cnt     <= '0;
            shift_reg <= '0;
            dout_q    <= '0;
            done_q    <= 1'b0;
            ferr_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bit   <= 1'b0;
            perr_q    <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (!rx_s) begin
                        state <= START;
                        s_cnt <= '0;
                    end
                end
                START: begin
                    if (bus.s_tick) begin
                        if (s_cnt == SW'(MID_TICK)) begin
                            if (!rx_s) begin
                                state <= DATA;
                                s_cnt <= '0;
                                n_cnt <= '0;
                            end else begin
                                state <= IDLE;
                            end
                        end else begin
                            s_cnt <= s_cnt + SW'(1);
                        end
                    end
                end
                DATA: begin
                    if (bus.s_tick) begin
                        if (s_cnt == SW'(OVERSAMPLE - 1)) begin
                            shift_reg <= {rx_s, shift_reg[DBIT-1:1]};
                            s_cnt     <= '0;
                            if (n_cnt == NW'(DBIT - 1)) begin
`ifdef UART_RX_PARITY_EN
                                state <= PARITY;
`else
                                state <= STOP;
`endif
                            end else begin
                                n_cnt <= n_cnt + NW'(1);
                            end
                        end else begin
                            s_cnt <= s_cnt + SW'(1);
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (bus.s_tick) begin
                        if (s_cnt == SW'(OVERSAMPLE - 1)) begin
                            par_bit <= rx_s;
                            s_cnt   <= '0;
                            state   <= STOP;
                        end else begin
                            s_cnt <= s_cnt + SW'(1);
                        end
                    end
                end
`endif
                STOP: begin
                    if (bus.s_tick) begin
                        if (s_cnt == SW'(SB_TICK - 1)) begin
                            state  <= IDLE;
                            dout_q <= shift_reg;
                            ferr_q <= ~rx_s;
                            done_q <= 1'b1;
`ifdef UART_RX_PARITY_EN
                            perr_q <= (^shift_reg) ^ par_bit ^ bus.parity_odd;
`endif
                        end else begin
                            s_cnt <= s_cnt + SW'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.dout         = dout_q;
    assign bus.rx_done_tick = done_q;
    assign bus.framing_err  = ferr_q;
`ifdef UART_RX_PARITY_EN
    assign bus.parity_err   = perr_q;
`endif
endmodule

// File: tb/tb_uart_rx_sampler.sv
// Self-checking bench for uart_rx_sampler; frames are built bit by bit from a byte model.
`timescale 1ns/1ps
module tb_uart_rx_sampler;
    localparam int DBIT     = 8;
    localparam int TICK_DIV = 4;
    localparam int BIT_CLK  = 16 * TICK_DIV;
`ifdef UART_RX_PARITY_EN
    localparam int PAR_BITS = 1;
`else
    localparam int PAR_BITS = 0;
`endif
    localparam int DONE_LAT = BIT_CLK * (1 + DBIT + PAR_BITS) + BIT_CLK / 2;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic par_odd = 1'b0;
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   tick_phase = 0;

    logic [DBIT-1:0] q_dout[$];
    logic            q_ferr[$];
    logic            q_perr[$];
    int              q_cyc[$];
    int              q_fall[$];

    uart_rx_sampler_if #(.DBIT(DBIT)) bus();

    uart_rx_sampler #(.DBIT(DBIT), .SB_TICK(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        bus.s_tick = 1'b0;
        forever begin
            @(negedge clk);
            tick_phase = (tick_phase + 1) % TICK_DIV;
            bus.s_tick = (tick_phase == 0);
        end
    end

    // Capture every done pulse; a pulse wider than one clk shows up as an extra entry
    always @(negedge clk) begin
        if (bus.rx_done_tick) begin
            q_dout.push_back(bus.dout);
            q_ferr.push_back(bus.framing_err);
            q_cyc.push_back(cyc);
`ifdef UART_RX_PARITY_EN
            q_perr.push_back(bus.parity_err);
`else
            q_perr.push_back(1'b0);
`endif
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    function automatic logic good_par(input logic [DBIT-1:0] d);
        return (^d) ^ par_odd;
    endfunction

    task automatic clear_q();
        q_dout.delete(); q_ferr.delete(); q_perr.delete(); q_cyc.delete(); q_fall.delete();
    endtask

    // Called aligned to a negedge; a low stop bit only covers the sample point so the
    // receiver does not mistake its tail for a new start bit
    task automatic send_frame(input logic [DBIT-1:0] d, input logic pbit, input logic stop_bit);
        bus.rx = 1'b0;
        q_fall.push_back(cyc);
        repeat (BIT_CLK) @(negedge clk);
        for (int i = 0; i < DBIT; i++) begin
            bus.rx = d[i];
            repeat (BIT_CLK) @(negedge clk);
        end
        if (PAR_BITS != 0) begin
            bus.rx = pbit;
            repeat (BIT_CLK) @(negedge clk);
        end
        if (stop_bit) begin
            bus.rx = 1'b1;
            repeat (BIT_CLK) @(negedge clk);
        end else begin
            bus.rx = 1'b0;
            repeat (BIT_CLK / 2 + 8) @(negedge clk);
            bus.rx = 1'b1;
            repeat (BIT_CLK / 2 - 8) @(negedge clk);
        end
        bus.rx = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.rx = 1'b1;
        repeat (4) @(negedge clk);
        total++; if (bus.dout !== 8'h00) begin bad++; $display("FAIL reset_dout got=%h exp=00", bus.dout); end
        total++; if (bus.rx_done_tick !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", bus.rx_done_tick); end
        total++; if (bus.framing_err !== 1'b0) begin bad++; $display("FAIL reset_ferr got=%b exp=0", bus.framing_err); end
`ifdef UART_RX_PARITY_EN
        total++; if (bus.parity_err !== 1'b0) begin bad++; $display("FAIL reset_perr got=%b exp=0", bus.parity_err); end
`endif
        reset = 1'b0;
        repeat (BIT_CLK) @(negedge clk);
    endtask

    task automatic test_basic();
        int lat;
        clear_q();
        send_frame(8'hA5, good_par(8'hA5), 1'b1);
        repeat (BIT_CLK) @(negedge clk);
        total++; if (q_dout.size() != 1) begin bad++; $display("FAIL basic_count got=%0d exp=1", q_dout.size()); end
        if (q_dout.size() >= 1) begin
            lat = q_cyc[0] - q_fall[0];
            total++; if (q_dout[0] !== 8'hA5) begin bad++; $display("FAIL basic_dout got=%h exp=a5", q_dout[0]); end
            total++; if (q_ferr[0] !== 1'b0) begin bad++; $display("FAIL basic_ferr got=%b exp=0", q_ferr[0]); end
            total++; if (lat < DONE_LAT - 8 || lat > DONE_LAT + 8) begin
                bad++; $display("FAIL basic_latency got=%0d exp=%0d+-8", lat, DONE_LAT);
            end
        end
        total++; if (bus.dout !== 8'hA5) begin bad++; $display("FAIL basic_dout_held got=%h exp=a5", bus.dout); end
    endtask

    task automatic test_glitch();
        clear_q();
        bus.rx = 1'b0;
        repeat (3 * TICK_DIV) @(negedge clk);
        bus.rx = 1'b1;
        repeat (12 * BIT_CLK) @(negedge clk);
        total++; if (q_dout.size() != 0) begin bad++; $display("FAIL glitch_count got=%0d exp=0", q_dout.size()); end
        total++; if (bus.dout !== 8'hA5) begin bad++; $display("FAIL glitch_dout got=%h exp=a5", bus.dout); end
        total++; if (bus.framing_err !== 1'b0) begin bad++; $display("FAIL glitch_ferr got=%b exp=0", bus.framing_err); end
    endtask

    task automatic test_framing();
        clear_q();
        send_frame(8'h3C, good_par(8'h3C), 1'b0);
        repeat (BIT_CLK) @(negedge clk);
        total++; if (q_dout.size() != 1) begin bad++; $display("FAIL ferr_count got=%0d exp=1", q_dout.size()); end
        total++; if (bus.dout !== 8'h3C) begin bad++; $display("FAIL ferr_dout got=%h exp=3c", bus.dout); end
        total++; if (bus.framing_err !== 1'b1) begin bad++; $display("FAIL ferr_flag got=%b exp=1", bus.framing_err); end
        send_frame(8'h3C, good_par(8'h3C), 1'b1);
        repeat (BIT_CLK) @(negedge clk);
        total++; if (q_dout.size() != 2) begin bad++; $display("FAIL ferr_clear_count got=%0d exp=2", q_dout.size()); end
        total++; if (bus.dout !== 8'h3C) begin bad++; $display("FAIL ferr_clear_dout got=%h exp=3c", bus.dout); end
        total++; if (bus.framing_err !== 1'b0) begin bad++; $display("FAIL ferr_clear_flag got=%b exp=0", bus.framing_err); end
    endtask

    task automatic test_back_to_back();
        clear_q();
        send_frame(8'h00, good_par(8'h00), 1'b1);
        send_frame(8'hFF, good_par(8'hFF), 1'b1);
        repeat (BIT_CLK) @(negedge clk);
        total++; if (q_dout.size() != 2) begin bad++; $display("FAIL b2b_count got=%0d exp=2", q_dout.size()); end
        if (q_dout.size() >= 2) begin
            total++; if (q_dout[0] !== 8'h00) begin bad++; $display("FAIL b2b_dout0 got=%h exp=00", q_dout[0]); end
            total++; if (q_dout[1] !== 8'hFF) begin bad++; $display("FAIL b2b_dout1 got=%h exp=ff", q_dout[1]); end
            total++; if (q_ferr[1] !== 1'b0) begin bad++; $display("FAIL b2b_ferr got=%b exp=0", q_ferr[1]); end
        end
    endtask

    task automatic test_reset_mid();
        logic [DBIT-1:0] d;
        clear_q();
        // Bits 4..7 high so the line stays idle once the aborted frame's tail arrives
        d = {4'hF, 4'($urandom_range(0, 15))};
        fork
            send_frame(d, 1'b1, 1'b1);
            begin
                repeat (BIT_CLK * 5 + BIT_CLK / 2) @(negedge clk);
                reset = 1'b1;
                @(negedge clk);
                reset = 1'b0;
                total++; if (bus.dout !== 8'h00) begin bad++; $display("FAIL rstmid_dout got=%h exp=00", bus.dout); end
                total++; if (bus.framing_err !== 1'b0) begin bad++; $display("FAIL rstmid_ferr got=%b exp=0", bus.framing_err); end
            end
        join
        repeat (2 * BIT_CLK) @(negedge clk);
        total++; if (q_dout.size() != 0) begin bad++; $display("FAIL rstmid_count got=%0d exp=0", q_dout.size()); end
        send_frame(8'h5A, good_par(8'h5A), 1'b1);
        repeat (BIT_CLK) @(negedge clk);
        total++; if (q_dout.size() != 1) begin bad++; $display("FAIL rstmid_next_count got=%0d exp=1", q_dout.size()); end
        total++; if (bus.dout !== 8'h5A) begin bad++; $display("FAIL rstmid_next_dout got=%h exp=5a", bus.dout); end
    endtask

    task automatic test_random();
        logic [DBIT-1:0] e_dout[$];
        logic            e_ferr[$];
        logic            e_perr[$];
        logic [DBIT-1:0] d;
        logic            pb;
        logic            sb;
        int              lat;
        clear_q();
        for (int f = 0; f < 8; f++) begin
            d  = DBIT'($urandom);
            pb = 1'($urandom_range(0, 1));
            sb = ($urandom_range(0, 3) != 0);
            e_dout.push_back(d);
            e_ferr.push_back(!sb);
            e_perr.push_back((^d) ^ pb ^ par_odd);
            send_frame(d, pb, sb);
            repeat (sb ? $urandom_range(0, 40) : BIT_CLK) @(negedge clk);
        end
        repeat (BIT_CLK) @(negedge clk);
        total++; if (q_dout.size() != e_dout.size()) begin
            bad++; $display("FAIL rand_count got=%0d exp=%0d", q_dout.size(), e_dout.size());
        end
        for (int i = 0; i < e_dout.size() && i < q_dout.size(); i++) begin
            lat = q_cyc[i] - q_fall[i];
            total++; if (q_dout[i] !== e_dout[i]) begin bad++; $display("FAIL rand_dout[%0d] got=%h exp=%h", i, q_dout[i], e_dout[i]); end
            total++; if (q_ferr[i] !== e_ferr[i]) begin bad++; $display("FAIL rand_ferr[%0d] got=%b exp=%b", i, q_ferr[i], e_ferr[i]); end
            total++; if (lat < DONE_LAT - 8 || lat > DONE_LAT + 8) begin
                bad++; $display("FAIL rand_latency[%0d] got=%0d exp=%0d+-8", i, lat, DONE_LAT);
            end
`ifdef UART_RX_PARITY_EN
            total++; if (q_perr[i] !== e_perr[i]) begin bad++; $display("FAIL rand_perr[%0d] got=%b exp=%b", i, q_perr[i], e_perr[i]); end
`endif
        end
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic test_parity();
        par_odd = 1'b0;
        bus.parity_odd = par_odd;
        clear_q();
        send_frame(8'h07, 1'b1, 1'b1);
        repeat (BIT_CLK) @(negedge clk);
        total++; if (bus.dout !== 8'h07) begin bad++; $display("FAIL par_dout got=%h exp=07", bus.dout); end
        total++; if (bus.parity_err !== 1'b0) begin bad++; $display("FAIL par_even_ok got=%b exp=0", bus.parity_err); end
        send_frame(8'h07, 1'b0, 1'b1);
        repeat (BIT_CLK) @(negedge clk);
        total++; if (bus.parity_err !== 1'b1) begin bad++; $display("FAIL par_even_bad got=%b exp=1", bus.parity_err); end
        par_odd = 1'b1;
        bus.parity_odd = par_odd;
        send_frame(8'h07, 1'b0, 1'b1);
        repeat (BIT_CLK) @(negedge clk);
        total++; if (bus.parity_err !== 1'b0) begin bad++; $display("FAIL par_odd_ok got=%b exp=0", bus.parity_err); end
        total++; if (q_dout.size() != 3) begin bad++; $display("FAIL par_count got=%0d exp=3", q_dout.size()); end
        par_odd = 1'b0;
        bus.parity_odd = par_odd;
    endtask
`endif

    initial begin
        bus.rx = 1'b1;
`ifdef UART_RX_PARITY_EN
        bus.parity_odd = par_odd;
`endif
        @(negedge clk);
        test_reset();
        test_basic();
        test_glitch();
        test_framing();
        test_back_to_back();
        test_reset_mid();
        test_random();
`ifdef UART_RX_PARITY_EN
        test_parity();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
